// File: rtl/id_ex_stage_if.sv
// Syscall request handshake between the ID/EX stage (master) and the syscall unit (slave).
interface id_ex_stage_if;
    logic syscall_fire;
    logic syscall_ack;

    modport master (output syscall_fire, input syscall_ack);
    modport slave  (input syscall_fire, output syscall_ack);
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a syscall drain/fire FSM.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegDst,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic        AluSrc,
    input  logic        MemWrite,
    input  logic        Syscall,
    input  logic [3:0]  AluOp,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        ex_RegDst,
    output logic        ex_Jump,
    output logic        ex_Jal,
    output logic        ex_Jr,
    output logic        ex_Branch,
    output logic        ex_MemRead,
    output logic        ex_MemToReg,
    output logic        ex_RegWrite,
    output logic        ex_AluSrc,
    output logic        ex_MemWrite,
    output logic        ex_Syscall,
    output logic [3:0]  ex_AluOp,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic        stall,
    id_ex_stage_if.master sc
);
    typedef struct packed {
        logic        RegDst, Jump, Jal, Jr, Branch, MemRead;
        logic        MemToReg, RegWrite, AluSrc, MemWrite, Syscall;
        logic [3:0]  AluOp;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } idex_t;

    typedef enum logic [1:0] {IDLE, DRAIN1, DRAIN2, FIRE} sc_state_t;

    idex_t     id_b, ex_q, ex_d;
    sc_state_t state_q, state_d;
    logic      fire_q, fire_d;
    logic      load_use, hold, ack_edge;

    assign id_b = {RegDst, Jump, Jal, Jr, Branch, MemRead, MemToReg, RegWrite, AluSrc,
                   MemWrite, Syscall, AluOp, id_pc4, id_rs_data, id_rt_data, id_imm,
                   id_rs, id_rt, id_rd};

    // Loads into $0 never create a real dependency.
    assign load_use = ex_q.MemRead && (ex_q.rt != 5'd0) &&
                      ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
    assign stall    = load_use || ex_q.Syscall;
    assign hold     = (state_q != IDLE) || ex_q.Syscall;
    assign ack_edge = (state_q == FIRE) && sc.syscall_ack;

    // The ack edge retires the held syscall, so it beats the hold.
    always_comb begin
        ex_d = ex_q;
        if (ack_edge)               ex_d = '0;
        else if (hold)              ex_d = ex_q;
        else if (flush || load_use) ex_d = '0;
        else                        ex_d = id_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    always_comb begin
        state_d = state_q;
        fire_d  = 1'b0;
        case (state_q)
            IDLE:    if (ex_q.Syscall) state_d = DRAIN1;
            DRAIN1:  state_d = DRAIN2;
            DRAIN2:  begin state_d = FIRE; fire_d = 1'b1; end
            FIRE:    if (sc.syscall_ack) state_d = IDLE; else fire_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fire_q  <= fire_d;
        end
    end

    assign sc.syscall_fire = fire_q;

    assign ex_RegDst   = ex_q.RegDst;
    assign ex_Jump     = ex_q.Jump;
    assign ex_Jal      = ex_q.Jal;
    assign ex_Jr       = ex_q.Jr;
    assign ex_Branch   = ex_q.Branch;
    assign ex_MemRead  = ex_q.MemRead;
    assign ex_MemToReg = ex_q.MemToReg;
    assign ex_RegWrite = ex_q.RegWrite;
    assign ex_AluSrc   = ex_q.AluSrc;
    assign ex_MemWrite = ex_q.MemWrite;
    assign ex_Syscall  = ex_q.Syscall;
    assign ex_AluOp    = ex_q.AluOp;
    assign ex_pc4      = ex_q.pc4;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX bundles are queued at drive time and popped after each edge.
module tb_id_ex_stage;
    typedef struct packed {
        logic        RegDst, Jump, Jal, Jr, Branch, MemRead;
        logic        MemToReg, RegWrite, AluSrc, MemWrite, Syscall;
        logic [3:0]  AluOp;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } bun_t;

    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h1;

    logic clk, rst_n, flush;
    bun_t id_b, got, e;
    bun_t exp_q[$];
    int   total, bad;

    logic ex_RegDst, ex_Jump, ex_Jal, ex_Jr, ex_Branch, ex_MemRead, ex_MemToReg;
    logic ex_RegWrite, ex_AluSrc, ex_MemWrite, ex_Syscall, stall;
    logic [3:0]  ex_AluOp;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    id_ex_stage_if sc();

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RegDst(id_b.RegDst), .Jump(id_b.Jump), .Jal(id_b.Jal), .Jr(id_b.Jr),
        .Branch(id_b.Branch), .MemRead(id_b.MemRead), .MemToReg(id_b.MemToReg),
        .RegWrite(id_b.RegWrite), .AluSrc(id_b.AluSrc), .MemWrite(id_b.MemWrite),
        .Syscall(id_b.Syscall), .AluOp(id_b.AluOp), .id_pc4(id_b.pc4),
        .id_rs_data(id_b.rs_data), .id_rt_data(id_b.rt_data), .id_imm(id_b.imm),
        .id_rs(id_b.rs), .id_rt(id_b.rt), .id_rd(id_b.rd), .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_Jal(ex_Jal), .ex_Jr(ex_Jr),
        .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg),
        .ex_RegWrite(ex_RegWrite), .ex_AluSrc(ex_AluSrc), .ex_MemWrite(ex_MemWrite),
        .ex_Syscall(ex_Syscall), .ex_AluOp(ex_AluOp), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall(stall), .sc(sc)
    );

    assign got = {ex_RegDst, ex_Jump, ex_Jal, ex_Jr, ex_Branch, ex_MemRead, ex_MemToReg,
                  ex_RegWrite, ex_AluSrc, ex_MemWrite, ex_Syscall, ex_AluOp, ex_pc4,
                  ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A flush while a syscall occupies EX is an illegal stimulus.
    always @(posedge clk)
        if (rst_n && flush && ex_Syscall) $error("illegal flush during syscall hold");

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic bun_t mk_add(input logic [4:0] rs, rt, rd, input logic [31:0] pc);
        bun_t b = '0;
        b.RegDst = 1'b1; b.RegWrite = 1'b1; b.AluOp = ALU_ADD; b.pc4 = pc;
        b.rs_data = 32'h1000_0000 + {27'd0, rs}; b.rt_data = 32'h2000_0000 + {27'd0, rt};
        b.imm = 32'hFFFF_FFF0; b.rs = rs; b.rt = rt; b.rd = rd;
        return b;
    endfunction

    function automatic bun_t mk_lw(input logic [4:0] rs, rt, input logic [31:0] pc);
        bun_t b = '0;
        b.MemRead = 1'b1; b.MemToReg = 1'b1; b.RegWrite = 1'b1; b.AluSrc = 1'b1;
        b.AluOp = ALU_ADD; b.pc4 = pc; b.rs_data = 32'h3000_0000 + {27'd0, rs};
        b.rt_data = 32'h4000_0000; b.imm = 32'h0000_0004; b.rs = rs; b.rt = rt;
        return b;
    endfunction

    function automatic bun_t mk_ori(input logic [4:0] rs, rt, input logic [31:0] pc);
        bun_t b = '0;
        b.AluSrc = 1'b1; b.RegWrite = 1'b1; b.AluOp = ALU_OR; b.pc4 = pc;
        b.rs_data = 32'h5000_0000 + {27'd0, rs}; b.imm = 32'h0000_00FF; b.rs = rs; b.rt = rt;
        return b;
    endfunction

    function automatic bun_t mk_sys(input logic [31:0] pc);
        bun_t b = '0;
        b.Syscall = 1'b1; b.pc4 = pc;
        return b;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (got !== '0) begin $display("FAIL reset_ex got=%h exp=0", got); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall); bad++; end
        total++; if (sc.syscall_fire !== 1'b0) begin $display("FAIL reset_fire got=%b exp=0", sc.syscall_fire); bad++; end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(id_b);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total++; if (got !== e) begin $display("FAIL reset_load got=%h exp=%h", got, e); bad++; end
        #2 rst_n = 1'b0;
        #1;
        total++; if (got !== '0) begin $display("FAIL reset_async got=%h exp=0", got); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL reset_async_stall got=%b exp=0", stall); bad++; end
        @(negedge clk);
        id_b  = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_straight();
        bun_t s[2];
        bit   st[2] = '{0, 0};
        s = '{mk_add(5'd8, 5'd9, 5'd10, 32'h104), mk_ori(5'd2, 5'd3, 32'h108)};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); id_b = s[i]; flush = 1'b0; exp_q.push_back(s[i]);
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL straight_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL straight_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
        end
    endtask

    task automatic test_load_use();
        bun_t s[8];
        bit   bub[8] = '{0, 1, 0, 0, 0, 0, 1, 0};
        bit   st[8]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        s = '{mk_lw(5'd1, 5'd9, 32'h200), mk_add(5'd9, 5'd2, 5'd10, 32'h204),
              mk_add(5'd9, 5'd2, 5'd10, 32'h204), mk_lw(5'd1, 5'd0, 32'h208),
              mk_add(5'd0, 5'd5, 5'd11, 32'h20c), mk_lw(5'd1, 5'd7, 32'h210),
              mk_add(5'd3, 5'd7, 5'd12, 32'h214), mk_add(5'd3, 5'd7, 5'd12, 32'h214)};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); id_b = s[i]; flush = 1'b0;
            exp_q.push_back(bub[i] ? bun_t'('0) : s[i]);
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL lu_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL lu_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
        end
    endtask

    task automatic test_flush();
        bun_t s[4];
        bit   fl[4]  = '{1, 0, 1, 0};
        bit   bub[4] = '{1, 0, 1, 0};
        bit   st[4]  = '{0, 0, 1, 0};
        s = '{mk_ori(5'd4, 5'd5, 32'h300), mk_lw(5'd1, 5'd9, 32'h304),
              mk_add(5'd9, 5'd2, 5'd10, 32'h308), mk_ori(5'd4, 5'd5, 32'h30c)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); id_b = s[i]; flush = fl[i];
            exp_q.push_back(bub[i] ? bun_t'('0) : s[i]);
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL flush_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL flush_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
        end
        flush = 1'b0;
    endtask

    task automatic test_xprop();
        bun_t s[3];
        bit   fl[3]  = '{0, 1, 0};
        bit   bub[3] = '{0, 1, 0};
        bun_t xa;
        xa = mk_add(5'd6, 5'd7, 5'd8, 32'h400);
        xa.RegDst = 1'bx; xa.MemToReg = 1'bx; xa.AluSrc = 1'bx;
        s = '{xa, xa, mk_add(5'd6, 5'd7, 5'd8, 32'h404)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); id_b = s[i]; flush = fl[i];
            exp_q.push_back(bub[i] ? bun_t'('0) : s[i]);
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL xprop_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
        end
        flush = 1'b0;
    endtask

    task automatic test_syscall();
        bun_t sy, nx;
        bit ack[10]  = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        bit st[10]   = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit fire[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        bit bub[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        sy = mk_sys(32'h600);
        nx = mk_add(5'd2, 5'd3, 5'd4, 32'h604);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); id_b = (i == 0) ? sy : nx; flush = 1'b0; sc.syscall_ack = ack[i];
            exp_q.push_back(bub[i] ? bun_t'('0) : ((i == 9) ? nx : sy));
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL sys_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL sys_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
            total++;
            if (sc.syscall_fire !== fire[i]) begin $display("FAIL sys_fire[%0d] got=%b exp=%b", i, sc.syscall_fire, fire[i]); bad++; end
        end
        sc.syscall_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        bun_t s[11];
        bun_t ea, eb, ad;
        bit ack[11]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit st[11]   = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit fire[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        bun_t ex[11];
        ea = mk_sys(32'h700); eb = mk_sys(32'h704); ad = mk_add(5'd5, 5'd6, 5'd7, 32'h708);
        s  = '{ea, eb, eb, eb, eb, eb, ad, ad, ad, ad, ad};
        ex = '{ea, ea, ea, ea, bun_t'('0), eb, eb, eb, eb, bun_t'('0), ad};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); id_b = s[i]; flush = 1'b0; sc.syscall_ack = ack[i];
            exp_q.push_back(ex[i]);
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL b2b_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
            total++;
            if (sc.syscall_fire !== fire[i]) begin $display("FAIL b2b_fire[%0d] got=%b exp=%b", i, sc.syscall_fire, fire[i]); bad++; end
        end
        sc.syscall_ack = 1'b0;
    endtask

    task automatic test_reset_fire();
        bun_t sy, nx, s[3];
        bit fire[4] = '{0, 0, 0, 1};
        bit st[3]   = '{0, 0, 1};
        bit bub[3]  = '{0, 0, 1};
        sy = mk_sys(32'h800); nx = mk_add(5'd2, 5'd3, 5'd4, 32'h804);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); id_b = (i == 0) ? sy : nx; flush = 1'b0; sc.syscall_ack = 1'b0;
            exp_q.push_back(sy);
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL rf_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
            total++;
            if (sc.syscall_fire !== fire[i]) begin $display("FAIL rf_fire[%0d] got=%b exp=%b", i, sc.syscall_fire, fire[i]); bad++; end
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (sc.syscall_fire !== 1'b0) begin $display("FAIL rf_async_fire got=%b exp=0", sc.syscall_fire); bad++; end
        total++; if (stall !== 1'b0) begin $display("FAIL rf_async_stall got=%b exp=0", stall); bad++; end
        total++; if (got !== '0) begin $display("FAIL rf_async_ex got=%h exp=0", got); bad++; end
        @(negedge clk);
        id_b = '0; rst_n = 1'b1;
        s = '{mk_ori(5'd4, 5'd5, 32'h810), mk_lw(5'd1, 5'd9, 32'h814), mk_add(5'd9, 5'd2, 5'd10, 32'h818)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); id_b = s[i]; flush = 1'b0;
            exp_q.push_back(bub[i] ? bun_t'('0) : s[i]);
            #1; total++;
            if (stall !== st[i]) begin $display("FAIL rf_post_stall[%0d] got=%b exp=%b", i, stall, st[i]); bad++; end
            @(posedge clk); #1; e = exp_q.pop_front(); total++;
            if (got !== e) begin $display("FAIL rf_post_ex[%0d] got=%h exp=%h", i, got, e); bad++; end
            total++;
            if (sc.syscall_fire !== 1'b0) begin $display("FAIL rf_post_fire[%0d] got=%b exp=0", i, sc.syscall_fire); bad++; end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; flush = 1'b0; sc.syscall_ack = 1'b0;
        id_b = mk_add(5'd8, 5'd9, 5'd10, 32'h100);
        test_reset();
        test_straight();
        test_load_use();
        test_flush();
        test_xprop();
        test_syscall();
        test_back_to_back();
        test_reset_fire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core. It captures the decoded control bundle from the control decoder together with decode-stage operands, and presents them registered to the execute stage. It also contains two pieces of logic. The first is the load-use hazard detector, which inserts a bubble and freezes the front end. The second is a syscall drain state machine: it holds a syscall in EX until older instructions retire, then hands it off to the syscall unit with a fire/ack handshake.

## Interface
- No parameters; all widths are fixed by the ISA (32-bit data, 5-bit register specifiers, 4-bit AluOp).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- RegDst, Jump, Jal, Jr, Branch, MemRead, MemToReg, RegWrite, AluSrc, MemWrite, Syscall  in  1 each  decoded control from the control decoder
- AluOp  in  4  decoded ALU operation
- id_pc4  in  32  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- flush  in  1  taken branch/jump: discard the ID instruction
- syscall_ack  in  1  syscall unit has consumed the request
- ex_RegDst … ex_Syscall, ex_AluOp  out  1/4  registered copies of every control input
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  32 each  registered operands
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- stall  out  1  combinational; freeze PC and the IF/ID register
- syscall_fire  out  1  registered; syscall request to the syscall unit

## Operation
- **Load-use detection:** load_use = ex_MemRead && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt).
- **Stall output:** stall = load_use || ex_Syscall.
- **Bubble:** all ex_ control bits = 0, ex_AluOp = 0, all data and specifier outputs = 0.
- **Per-edge priority, highest first:**
  - reset;
  - FSM not IDLE, or ex_Syscall set: hold, except on the ack cycle below;
  - flush: bubble;
  - load_use: bubble;
  - otherwise load all inputs.
- **X propagation:** X inputs on RegDst, MemToReg and AluSrc are captured as-is. A bubble forces them to 0.
- **Syscall FSM states:** IDLE, DRAIN1, DRAIN2, FIRE.
  - IDLE → DRAIN1 when ex_Syscall = 1.
  - DRAIN1 → DRAIN2 unconditionally.
  - DRAIN2 → FIRE unconditionally; syscall_fire is set on this edge.
  - FIRE: syscall_fire stays 1 until syscall_ack is seen.
  - FIRE with syscall_ack = 1 → IDLE. On the same edge, syscall_fire clears and ID/EX loads a bubble, retiring the syscall.
- **Ignored inputs:**
  - flush is ignored while ex_Syscall = 1 or the state is not IDLE; a flush there is illegal and the bench asserts it never occurs.
  - syscall_ack outside FIRE is ignored.

## Timing
- **Reset:** rst_n low asynchronously clears every ex_ output and syscall_fire to 0, and sets the state to IDLE. stall therefore reads 0 during reset.
- **Normal latency:** inputs appear on ex_ outputs 1 cycle after the capturing edge.
- **Load-use:** stall is high for exactly 1 cycle per load-use pair. The following edge inserts one bubble, after which the dependent instruction is re-presented and loads normally.
- **Simultaneous flush and load_use:** bubble; stall is still asserted that cycle, which is harmless because the ID instruction is discarded anyway.
- **Syscall:** it enters EX at edge N.
  - stall is high from N until the ack edge.
  - syscall_fire rises at edge N+3.
  - If ack is already high at the first FIRE cycle, fire is 1 cycle wide.
  - The front end resumes the cycle after the ack edge.
- **Reset mid-drain or mid-FIRE:** immediate return to IDLE with fire low. No residual stall.
- **Back-to-back syscalls:** the second is held in ID by stall. It enters EX on the ack edge +1 and starts a fresh drain.

## Test plan
- **Reset:** rst_n low mid-cycle with non-zero ex_ outputs → all outputs 0 asynchronously; stall = 0.
- **Straight-line:** ADD with rs = 8, rt = 9, rd = 10 → next edge ex_RegWrite = 1, ex_AluOp = ADD code, ex_rd = 10, stall = 0.
- **Load-use and $0 exemption:**
  - LW to $9, then ADD reading $9 → stall = 1 for one cycle, one bubble (ex_RegWrite = 0, ex_MemRead = 0), then ADD loads.
  - The same sequence with a load to $0 → no stall.
- **Flush:** flush = 1 with ORI in ID → ex_ outputs all 0 next edge. Flush together with load_use → bubble, no extra stall cycle.
- **Syscall drain:**
  - Syscall captured at edge N → stall high from N; syscall_fire = 1 at N+3.
  - ack held low 4 cycles, then high → fire drops and ID/EX bubbles on the ack edge; stall low afterwards.
- **Reset during FIRE:** rst_n low while syscall_fire = 1 → fire = 0 and state IDLE; after release, normal loading resumes.
